// File: rtl/conv3x3_window_feeder.sv
// Source-side sequencer for the 3x3 conv PE chain: buffers a raster pixel stream in a
// 3-row circular line memory and serializes each complete window as 9 (pixel, weight) taps.
module conv3x3_window_feeder #(
  parameter int unsigned X_BW  = 8,
  parameter int unsigned W_BW  = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pix_valid,
  input  logic [X_BW-1:0] i_pix,
  output logic            o_pix_ready,
  input  logic            i_w_we,
  input  logic [3:0]      i_w_addr,
  input  logic [W_BW-1:0] i_w_data,
  output logic [X_BW-1:0] o_x,
  output logic [W_BW-1:0] o_w,
  output logic            o_tap_valid,
  output logic            o_tap_first,
  output logic            o_tap_last,
  output logic            o_frame_done,
  output logic            o_busy
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic [0:0] {StAccept, StIssue} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, tcol_q, tcol_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      lrow_q, lrow_d, trow_q, trow_d;
  logic [3:0]      k_q, k_d;
  logic            done_pend_q, done_pend_d;
  logic [W_BW-1:0] kern_q [9];
  logic [W_BW-1:0] kern_d [9];
  logic [X_BW-1:0] line_q [3][IMG_W];

  logic [X_BW-1:0] x_q, x_d;
  logic [W_BW-1:0] w_q, w_d;
  logic            valid_q, valid_d, first_q, first_d, last_q, last_d, fdone_q, fdone_d;

  logic            accept, trigger, kern_we, last_row, last_col;
  logic [3:0]      tap_k;
  logic [1:0]      tap_r, tap_c, base_lrow, src_row;
  logic [2:0]      rsum;
  logic [CW-1:0]   base_col, src_col;
  logic [X_BW-1:0] tap_x;
  logic [W_BW-1:0] tap_w;

  assign o_pix_ready = (state_q == StAccept);
  assign o_busy      = (state_q == StIssue);
  assign accept      = i_pix_valid && (state_q == StAccept);
  assign last_row    = (row_q == RW'(IMG_H - 1));
  assign last_col    = (col_q == CW'(IMG_W - 1));
  assign trigger     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign kern_we     = (state_q == StAccept) && i_w_we && (i_w_addr <= 4'd8);

  // Next kernel state; the tap weight reads from it so a same-cycle write reaches the window.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      kern_d[i] = kern_q[i];
      if (kern_we && (i_w_addr == 4'(i))) kern_d[i] = i_w_data;
    end
  end

  // Tap source: tap 0 is fetched at the trigger edge from live coordinates, later taps
  // from the latched ones. Row (R-2+r) mod 3 is (R mod 3 + 1 + r) mod 3.
  always_comb begin
    tap_k     = (state_q == StAccept) ? 4'd0 : k_q;
    base_lrow = (state_q == StAccept) ? lrow_q : trow_q;
    base_col  = (state_q == StAccept) ? col_q : tcol_q;
    unique case (tap_k)
      4'd0:    begin tap_r = 2'd0; tap_c = 2'd0; end
      4'd1:    begin tap_r = 2'd0; tap_c = 2'd1; end
      4'd2:    begin tap_r = 2'd0; tap_c = 2'd2; end
      4'd3:    begin tap_r = 2'd1; tap_c = 2'd0; end
      4'd4:    begin tap_r = 2'd1; tap_c = 2'd1; end
      4'd5:    begin tap_r = 2'd1; tap_c = 2'd2; end
      4'd6:    begin tap_r = 2'd2; tap_c = 2'd0; end
      4'd7:    begin tap_r = 2'd2; tap_c = 2'd1; end
      4'd8:    begin tap_r = 2'd2; tap_c = 2'd2; end
      default: begin tap_r = 2'd0; tap_c = 2'd0; end
    endcase
    rsum    = 3'(base_lrow) + 3'd1 + 3'(tap_r);
    src_row = (rsum >= 3'd3) ? 2'(rsum - 3'd3) : rsum[1:0];
    src_col = base_col - CW'(2) + CW'(tap_c);
    tap_x   = line_q[src_row][src_col];
    tap_w   = '0;
    for (int i = 0; i < 9; i++) begin
      if (tap_k == 4'(i)) tap_w = kern_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    lrow_d      = lrow_q;
    tcol_d      = tcol_q;
    trow_d      = trow_q;
    k_d         = k_q;
    done_pend_d = done_pend_q;
    x_d         = '0;
    w_d         = '0;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    fdone_d     = 1'b0;
    unique case (state_q)
      StAccept: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d  = '0;
              lrow_d = 2'd0;
            end else begin
              row_d  = row_q + RW'(1);
              lrow_d = (lrow_q == 2'd2) ? 2'd0 : lrow_q + 2'd1;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        if (trigger) begin
          state_d     = StIssue;
          trow_d      = lrow_q;
          tcol_d      = col_q;
          done_pend_d = last_row && last_col;
          k_d         = 4'd1;
          x_d         = tap_x;
          w_d         = tap_w;
          valid_d     = 1'b1;
          first_d     = 1'b1;
        end
      end
      StIssue: begin
        // k_q == 9 is the drain cycle that shows tap 8 while returning to accept.
        if (k_q <= 4'd8) begin
          x_d     = tap_x;
          w_d     = tap_w;
          valid_d = 1'b1;
          last_d  = (k_q == 4'd8);
          fdone_d = (k_q == 4'd8) && done_pend_q;
          k_d     = k_q + 4'd1;
        end else begin
          state_d = StAccept;
          k_d     = 4'd0;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StAccept;
      col_q       <= '0;
      row_q       <= '0;
      lrow_q      <= 2'd0;
      tcol_q      <= '0;
      trow_q      <= 2'd0;
      k_q         <= 4'd0;
      done_pend_q <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      fdone_q     <= 1'b0;
      for (int i = 0; i < 9; i++) kern_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lrow_q      <= lrow_d;
      tcol_q      <= tcol_d;
      trow_q      <= trow_d;
      k_q         <= k_d;
      done_pend_q <= done_pend_d;
      x_q         <= x_d;
      w_q         <= w_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      fdone_q     <= fdone_d;
      for (int i = 0; i < 9; i++) kern_q[i] <= kern_d[i];
    end
  end

  // Line memory contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && accept) line_q[lrow_q][col_q] <= i_pix;
  end

  assign o_x          = x_q;
  assign o_w          = w_q;
  assign o_tap_valid  = valid_q;
  assign o_tap_first  = first_q;
  assign o_tap_last   = last_q;
  assign o_frame_done = fdone_q;

endmodule
